// File: rtl/image_proc_ctrl.sv
// Bayer capture controller: counts raw pixels and emits raw/gray/sobel output coords, 1-cycle registered, no backpressure.
// Define IPC_BORDER_MASK_EN to also emit Sobel border samples flagged with out_border.
module image_proc_ctrl #(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 960
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        frame_start,
  input  logic [1:0]  mode_req,
  input  logic        mode_load,
  output logic        mode_ack,
  output logic [1:0]  mode_active,
  output logic        out_valid,
  output logic        out_border,
  output logic [11:0] out_col,
  output logic [11:0] out_row,
  output logic        frame_done,
  output logic        busy,
  output logic        sync_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [11:0] COL_LAST   = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] ROW_LAST   = 12'(IMG_HEIGHT - 1);
  localparam logic [1:0]  MODE_RAW   = 2'b00;
  localparam logic [1:0]  MODE_GRAY  = 2'b01;
  localparam logic [1:0]  MODE_SOBEL = 2'b10;

  state_t      state, state_nxt;
  logic [11:0] col, row, col_nxt, row_nxt;
  logic [1:0]  pend_mode, pend_mode_nxt, mode_nxt;
  logic        pend_vld, pend_vld_nxt, ack_nxt;
  logic        take, sync_hit;
  logic [11:0] px_col, px_row;
  logic [1:0]  px_mode;

  // px_* describe the pixel counted this cycle; a frame_start pixel always sits at (0,0).
  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    row_nxt       = row;
    pend_mode_nxt = pend_mode;
    pend_vld_nxt  = pend_vld;
    mode_nxt      = mode_active;
    ack_nxt       = 1'b0;
    take          = 1'b0;
    sync_hit      = 1'b0;
    px_col        = col;
    px_row        = row;
    px_mode       = mode_active;
    case (state)
      IDLE: begin
        if (mode_load) begin
          mode_nxt = mode_req;
          ack_nxt  = 1'b1;
        end
        if (in_valid && frame_start) begin
          take    = 1'b1;
          px_col  = 12'd0;
          px_row  = 12'd0;
          px_mode = mode_nxt;
        end
      end
      ACTIVE: begin
        if (in_valid && frame_start) begin
          sync_hit = 1'b1;
          take     = 1'b1;
          px_col   = 12'd0;
          px_row   = 12'd0;
          if (pend_vld) begin
            mode_nxt     = pend_mode;
            ack_nxt      = 1'b1;
            pend_vld_nxt = 1'b0;
          end
          px_mode = mode_nxt;
        end else if (in_valid) begin
          take = 1'b1;
        end
        if (mode_load) begin
          pend_vld_nxt  = 1'b1;
          pend_mode_nxt = mode_req;
        end
      end
      DONE: begin
        if (mode_load) begin
          mode_nxt = mode_req;
          ack_nxt  = 1'b1;
        end else if (pend_vld) begin
          mode_nxt = pend_mode;
          ack_nxt  = 1'b1;
        end
        pend_vld_nxt = 1'b0;
        state_nxt    = IDLE;
        if (in_valid && frame_start) begin
          take    = 1'b1;
          px_col  = 12'd0;
          px_row  = 12'd0;
          px_mode = mode_nxt;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (take) begin
      if (px_col == COL_LAST) begin
        col_nxt = 12'd0;
        if (px_row == ROW_LAST) begin
          row_nxt   = 12'd0;
          state_nxt = DONE;
        end else begin
          row_nxt   = px_row + 12'd1;
          state_nxt = ACTIVE;
        end
      end else begin
        col_nxt   = px_col + 12'd1;
        row_nxt   = px_row;
        state_nxt = ACTIVE;
      end
    end
  end

  logic [11:0] gcol, grow, ocol_nxt, orow_nxt;
  logic        gray_hit, core_hit, ov_nxt;
`ifdef IPC_BORDER_MASK_EN
  logic        bd_nxt;
`endif

  // Gray samples land on odd/odd raw positions; Sobel reports the 3x3 window centre.
  always_comb begin
    gcol     = {1'b0, px_col[11:1]};
    grow     = {1'b0, px_row[11:1]};
    gray_hit = take && px_col[0] && px_row[0];
    core_hit = gray_hit && (gcol >= 12'd2) && (grow >= 12'd2);
    ov_nxt   = 1'b0;
    ocol_nxt = out_col;
    orow_nxt = out_row;
`ifdef IPC_BORDER_MASK_EN
    bd_nxt   = 1'b0;
`endif
    case (px_mode)
      MODE_RAW: begin
        if (take) begin
          ov_nxt   = 1'b1;
          ocol_nxt = px_col;
          orow_nxt = px_row;
        end
      end
      MODE_SOBEL: begin
        if (core_hit) begin
          ov_nxt   = 1'b1;
          ocol_nxt = gcol - 12'd1;
          orow_nxt = grow - 12'd1;
        end
`ifdef IPC_BORDER_MASK_EN
        else if (gray_hit) begin
          ov_nxt   = 1'b1;
          bd_nxt   = 1'b1;
          ocol_nxt = gcol;
          orow_nxt = grow;
        end
`endif
      end
      default: begin
        if (gray_hit) begin
          ov_nxt   = 1'b1;
          ocol_nxt = gcol;
          orow_nxt = grow;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      col         <= 12'd0;
      row         <= 12'd0;
      pend_vld    <= 1'b0;
      pend_mode   <= 2'b00;
      mode_active <= MODE_GRAY;
      mode_ack    <= 1'b0;
      out_valid   <= 1'b0;
      out_col     <= 12'd0;
      out_row     <= 12'd0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      row         <= row_nxt;
      pend_vld    <= pend_vld_nxt;
      pend_mode   <= pend_mode_nxt;
      mode_active <= mode_nxt;
      mode_ack    <= ack_nxt;
      out_valid   <= ov_nxt;
      out_col     <= ocol_nxt;
      out_row     <= orow_nxt;
      sync_err    <= sync_err | sync_hit;
    end
  end

`ifdef IPC_BORDER_MASK_EN
  always_ff @(posedge clk) begin
    if (rst) out_border <= 1'b0;
    else     out_border <= bd_nxt;
  end
`else
  assign out_border = 1'b0;
`endif

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule
